pc_unit_pipe: RTL and testbench
===============================

Name: pc_unit_pipe

Overview:
- Parametrised, registered program-counter unit for the pipelined core. It holds the fetch PC and advances it by one instruction per cycle.
- It resolves conditional branches from the decode stage, supporting both immediate-relative B and register-indirect BR. On a taken branch it issues a one-cycle flush.
- It latches a sticky halt state. It counts taken branches for performance monitoring.

Parameters:
- ADDR_W, 16, PC / address width in bits.
- OFF_W, 9, width of the signed branch offset field (word offset, in instructions).
- INSTR_BYTES, 2, byte increment per sequential instruction.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the taken-branch counter (saturating).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC (pipeline back-pressure).
- hlt_in  in  1  HLT instruction seen at fetch.
- br_valid  in  1  decode stage presents a branch this cycle.
- br_reg  in  1  0 = B (PC-relative), 1 = BR (target = br_rs_data).
- br_cond  in  3  condition code C.
- br_off  in  OFF_W  signed word offset I.
- br_pc  in  ADDR_W  PC of the branch instruction being resolved.
- br_rs_data  in  ADDR_W  register target for BR.
- flags  in  3  {Z, V, N}.
- pc  out  ADDR_W  current fetch PC (registered).
- pc_plus  out  ADDR_W  pc + INSTR_BYTES (combinational, mod 2^ADDR_W).
- taken  out  1  combinational: br_valid and condition true this cycle.
- flush  out  1  registered; 1 for exactly the cycle following a taken branch.
- halted  out  1  registered sticky halt indication.
- taken_cnt  out  CNT_W  number of taken branches, saturating.

Behaviour:
- Reset (rst=1 at edge) sets pc=RESET_PC, flush=0, halted=0, taken_cnt=0, FSM=RUN. Reset overrides every other input, in any state.
- FSM states: RUN and HALT.
  - RUN->HALT when hlt_in=1 and no taken branch in that cycle.
  - HALT is left only by reset.
- Condition true per br_cond, with Z=flags[2], V=flags[1], N=flags[0]:
  - 000: !Z
  - 001: Z
  - 010: !Z & !N
  - 011: N
  - 100: Z | (!Z & !N)
  - 101: N | Z
  - 110: V
  - 111: 1
- taken = br_valid & cond_true & (state==RUN).
- Branch target:
  - B: br_pc + INSTR_BYTES + (sign_extend(br_off) << 1), mod 2^ADDR_W, wrap silent.
  - BR: br_rs_data.
- Next-PC priority in RUN, highest first:
  - taken: pc <= target.
  - stall: hold.
  - hlt_in: hold.
  - else: pc <= pc + INSTR_BYTES, wrapping at 2^ADDR_W.
- Taken branch overrides stall and hlt_in in the same cycle. The halt is treated as wrong-path and ignored; FSM stays RUN.
- Latency: branch resolved in cycle N gives pc=target and flush=1 in cycle N+1. flush returns to 0 in N+2 unless another taken branch occurred in N+1.
- Back-to-back taken branches in consecutive cycles: each redirect takes effect. flush stays high continuously.
- HALT: pc frozen, halted=1, taken=0, flush=0, taken_cnt frozen. br_valid, stall and hlt_in are ignored.
- halted rises in the cycle after hlt_in is accepted. pc equals the HLT's PC from that point.
- taken_cnt increments by 1 on each taken cycle. It saturates at 2^CNT_W-1 with no wrap.
- pc_plus is always derived from the current registered pc, including in HALT.

Test Plan:
- Reset then 4 free-run cycles, INSTR_BYTES=2 -> pc = 0,2,4,6,8; flush=0; halted=0.
- pc=0x0010, br_valid=1, br_reg=0, br_cond=001, flags=100, br_pc=0x000C, br_off=9'h1FE (-2) -> next cycle pc=0x000A, flush=1, taken_cnt=1; cycle after that flush=0.
- br_cond=010 with flags=001, then flags=000 on BR with br_rs_data=0x1234 -> first not taken (pc+2); second gives pc=0x1234 next cycle.
- stall=1 and hlt_in=1 together with a taken branch to 0x0040 -> pc=0x0040, FSM stays RUN, halted=0; then hlt_in alone -> pc holds, halted=1 next cycle, later br_valid with br_cond=111 ignored.
- Wrap: pc=0xFFFE, no branch -> pc=0x0000; B with br_pc=0xFFFC, br_off=+2 -> target 0x0002.
- CNT_W=2, 5 consecutive unconditional taken branches -> taken_cnt 1,2,3,3,3 and flush held high; assert rst mid-sequence -> pc=RESET_PC, taken_cnt=0, flush=0 next cycle.

Source files
------------

// File: rtl/pc_unit_pipe_if.sv
// Branch/control bus between decode, fetch and the PC unit.
// master drives branch/control inputs; slave is the PC unit.
interface pc_unit_pipe_if #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 9,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              hlt_in;
  logic              br_valid;
  logic              br_reg;
  logic [2:0]        br_cond;
  logic [OFF_W-1:0]  br_off;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_rs_data;
  logic [2:0]        flags;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              taken;
  logic              flush;
  logic              halted;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output stall, hlt_in, br_valid, br_reg,
    output br_cond, br_off, br_pc,
    output br_rs_data, flags,
    input  pc, pc_plus, taken, flush,
    input  halted, taken_cnt
  );

  modport slave (
    input  stall, hlt_in, br_valid, br_reg,
    input  br_cond, br_off, br_pc,
    input  br_rs_data, flags,
    output pc, pc_plus, taken, flush,
    output halted, taken_cnt
  );
endinterface

// File: rtl/pc_unit_pipe.sv
// Fetch PC unit: sequential advance, B/BR branch resolve, flush, sticky halt.
// Ports: clk, rst (sync, active-high), bus (pc_unit_pipe_if.slave).
module pc_unit_pipe #(
  parameter int ADDR_W      = 16,
  parameter int OFF_W       = 9,
  parameter int INSTR_BYTES = 2,
  parameter int RESET_PC    = 0,
  parameter int CNT_W       = 16
) (
  input logic           clk,
  input logic           rst,
  pc_unit_pipe_if.slave bus
);
  localparam logic [ADDR_W-1:0] INC =
    ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] RST_PC =
    ADDR_W'(RESET_PC);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic              flush_q;
  logic              halted_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              z, v, n;
  logic              cond_true;
  logic              taken;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] target;

  assign z = bus.flags[2];
  assign v = bus.flags[1];
  assign n = bus.flags[0];

  always_comb begin
    cond_true = 1'b0;
    unique case (bus.br_cond)
      3'b000: cond_true = !z;
      3'b001: cond_true = z;
      3'b010: cond_true = !z && !n;
      3'b011: cond_true = n;
      3'b100: cond_true = z || (!z && !n);
      3'b101: cond_true = n || z;
      3'b110: cond_true = v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign taken = bus.br_valid && cond_true &&
                 (state == RUN);

  // word offset -> byte offset, relative to the
  // instruction after the branch
  assign off_ext = ADDR_W'(
    $signed(bus.br_off));
  assign target = bus.br_reg ? bus.br_rs_data :
    bus.br_pc + INC + (off_ext << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc_q     <= RST_PC;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      flush_q <= taken;
      if (state == RUN) begin
        if (taken) begin
          pc_q <= target;
        end else if (!bus.stall && !bus.hlt_in) begin
          pc_q <= pc_q + INC;
        end
        // a halt beside a taken branch is wrong-path
        if (bus.hlt_in && !taken) begin
          state    <= HALT;
          halted_q <= 1'b1;
        end
        if (taken && (cnt_q != '1)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus   = pc_q + INC;
  assign bus.taken     = taken;
  assign bus.flush     = flush_q;
  assign bus.halted    = halted_q;
  assign bus.taken_cnt = cnt_q;
endmodule

// File: tb/tb_pc_unit_pipe.sv
// Scoreboard bench for pc_unit_pipe: directed cases
// plus random traffic against a behavioural model.
module tb_pc_unit_pipe;
  localparam int AW = 16;
  localparam int OW = 9;
  localparam int CW = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_pipe_if #(
    .ADDR_W(AW), .OFF_W(OW), .CNT_W(CW)
  ) bus ();

  pc_unit_pipe #(
    .ADDR_W(AW), .OFF_W(OW), .INSTR_BYTES(2),
    .RESET_PC(0), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int pc;
    int pc_plus;
    int taken;
    int flush;
    int halted;
    int cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int m_pc = 0;
  int m_flush = 0;
  int m_halt = 0;
  int m_cnt = 0;
  bit m_known = 1'b0;

  function automatic bit cond_ok(
    input int c, input int fl);
    bit z, v, n;
    z = fl[2];
    v = fl[1];
    n = fl[0];
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name,
    input logic [31:0] act,
    input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
        name, act, want);
    end
  endtask

  task automatic step(
    input bit r, input bit st, input bit hl,
    input bit bv, input bit brg,
    input int c, input int off,
    input int bpc, input int rs,
    input int fl);
    exp_t e;
    bit tk;
    int soff, tgt;
    @(posedge clk);
    #1;
    rst = r;
    bus.stall = st;
    bus.hlt_in = hl;
    bus.br_valid = bv;
    bus.br_reg = brg;
    bus.br_cond = 3'(c);
    bus.br_off = 9'(off);
    bus.br_pc = 16'(bpc);
    bus.br_rs_data = 16'(rs);
    bus.flags = 3'(fl);
    tk = bv && cond_ok(c, fl) && (m_halt == 0);
    if (m_known) begin
      e.pc = m_pc;
      e.pc_plus = (m_pc + 2) % 65536;
      e.taken = tk;
      e.flush = m_flush;
      e.halted = m_halt;
      e.cnt = m_cnt;
      q.push_back(e);
    end
    soff = off % 512;
    if (soff >= 256) soff -= 512;
    tgt = brg ? (rs % 65536) :
      ((bpc + 2 + 2 * soff) % 65536 + 65536) % 65536;
    if (r) begin
      m_pc = 0;
      m_flush = 0;
      m_halt = 0;
      m_cnt = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (m_halt != 0) begin
        m_flush = 0;
      end else begin
        m_flush = tk;
        if (tk) begin
          m_pc = tgt;
          if (m_cnt < CMAX) m_cnt++;
        end else if (!st && !hl) begin
          m_pc = (m_pc + 2) % 65536;
        end
        if (hl && !tk) m_halt = 1;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", 32'(bus.pc), e.pc);
        chk("pc_plus", 32'(bus.pc_plus), e.pc_plus);
        chk("taken", 32'(bus.taken), e.taken);
        chk("flush", 32'(bus.flush), e.flush);
        chk("halted", 32'(bus.halted), e.halted);
        chk("cnt", 32'(bus.taken_cnt), e.cnt);
      end
    end
  end

  initial begin : driver
    int drain;
    bus.stall = 0;
    bus.hlt_in = 0;
    bus.br_valid = 0;
    bus.br_reg = 0;
    bus.br_cond = 0;
    bus.br_off = 0;
    bus.br_pc = 0;
    bus.br_rs_data = 0;
    bus.flags = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_cnt", 32'(bus.taken_cnt), 0);
    repeat (7) idle();
    chk("run_pc", 32'(bus.pc), 32'h0e);
    // pc 0x10: B back to 0x0A
    step(0, 0, 0, 1, 0, 1, 'h1fe, 'h0c, 0, 4);
    idle();
    chk("b_pc", 32'(bus.pc), 32'h0a);
    chk("b_flush", 32'(bus.flush), 1);
    chk("b_cnt", 32'(bus.taken_cnt), 1);
    idle();
    chk("b_flush_off", 32'(bus.flush), 0);
    step(0, 0, 0, 1, 1, 2, 0, 0, 'h1234, 1);
    step(0, 0, 0, 1, 1, 2, 0, 0, 'h1234, 0);
    chk("nt_pc", 32'(bus.pc), 32'h10);
    step(0, 1, 1, 1, 1, 7, 0, 0, 'h40, 0);
    chk("br_pc", 32'(bus.pc), 32'h1234);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("ovr_pc", 32'(bus.pc), 32'h40);
    chk("ovr_halted", 32'(bus.halted), 0);
    repeat (3) begin
      step(0, 1, 1, 1, 1, 7, 0, 0, 'h80, 0);
      chk("hlt_pc", 32'(bus.pc), 32'h40);
      chk("hlt_halted", 32'(bus.halted), 1);
      chk("hlt_cnt", 32'(bus.taken_cnt), 3);
    end

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 7, 0, 0, 'hfffe, 0);
    idle();
    chk("wrap_hi", 32'(bus.pc), 32'hfffe);
    step(0, 0, 0, 1, 0, 7, 2, 'hfffc, 0, 0);
    chk("wrap_pc", 32'(bus.pc), 32'h0);
    idle();
    chk("wrap_tgt", 32'(bus.pc), 32'h2);

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(i == 5, 0, 0, 1, 1, 7, 0, 0,
        'h100 + i * 4, 0);
      if (i >= 1 && i <= 5) begin
        chk("sat_cnt", 32'(bus.taken_cnt),
          (i < CMAX) ? i : CMAX);
        chk("sat_flush", 32'(bus.flush), 1);
      end
    end
    chk("mid_rst_pc", 32'(bus.pc), 0);
    chk("mid_rst_cnt", 32'(bus.taken_cnt), 0);
    chk("mid_rst_flush", 32'(bus.flush), 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) == 0,
        $urandom_range(4) == 0,
        $urandom_range(39) == 0,
        $urandom_range(2) == 0,
        $urandom_range(1),
        $urandom_range(7),
        $urandom_range(511),
        $urandom_range(65535),
        $urandom_range(65535),
        $urandom_range(7));
    end
    idle();
    drain = 0;
    while (q.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d want 0",
        q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
